io_host: RTL and testbench

IO_HOST -- requirements
Module: io_host

---
 rtl/io_pkg.sv | 31 +++
 rtl/io_delay_counter.sv | 36 +++
 rtl/io_host.sv | 151 +++++++++++++++
 tb/tb_io_host.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared types and default timing for the io host driver.
// Imported by the host RTL and its bench.
package io_pkg;

    localparam int HOLD_DEF    = 4;
    localparam int GAP_DEF     = 2;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [3:0] {
        IDLE,
        SEND_X,
        HS_X,
        GAP_X,
        SEND_Y,
        HS_Y,
        GAP_Y,
        WAIT_X2,
        SHOW_X2,
        WAIT_Y2,
        RELEASE
    } io_state_e;

    function automatic int cnt_width(input int h, input int g, input int t);
        int m;
        m = h;
        if (g > m) m = g;
        if (t > m) m = t;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/io_delay_counter.sv
// Loadable down-counter with a zero flag.
// Shared by phase timing and result timeout.
module io_delay_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/io_host.sv
// Host-side driver for the processor io block: presents two operands
// over a switch-style handshake and collects two strobed results.
module io_host
    import io_pkg::*;
#(
    parameter int N       = 8,
    parameter int HOLD    = HOLD_DEF,
    parameter int GAP     = GAP_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] x1,
    input  logic [N-1:0] y1,
    output logic [N-1:0] in,
    output logic         handshake,
    input  logic [N-1:0] out,
    input  logic         write_out,
    output logic [N-1:0] x2,
    output logic [N-1:0] y2,
    output logic         busy,
    output logic         done,
    output logic         timeout
);

    localparam int CW = cnt_width(HOLD, GAP, TIMEOUT);
    localparam logic [CW-1:0] GAP_L  = CW'(GAP - 1);
    localparam logic [CW-1:0] HOLD_L = CW'(HOLD - 1);
    localparam logic [CW-1:0] TMO_L  = CW'(TIMEOUT - 1);

    io_state_e state_q, state_d, nxt;
    logic [N-1:0] in_q, in_d, y1_q, y1_d;
    logic [N-1:0] x2_q, x2_d, y2_q, y2_d;
    logic to_q, to_d, done_q, done_d, cap_q, cap_d;
    logic ld, dec, zero, timed;
    logic [CW-1:0] ld_val, nxt_len;

    io_delay_counter #(.W(CW)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (ld),
        .load_val (ld_val),
        .dec      (dec),
        .zero     (zero)
    );

    always_comb begin
        state_d = state_q;
        in_d    = in_q;
        y1_d    = y1_q;
        x2_d    = x2_q;
        y2_d    = y2_q;
        to_d    = to_q;
        done_d  = 1'b0;
        cap_d   = cap_q;
        ld      = 1'b0;
        ld_val  = '0;
        dec     = 1'b0;
        timed   = 1'b0;
        nxt     = state_q;
        nxt_len = '0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    y1_d    = y1;
                    in_d    = x1;
                    to_d    = 1'b0;
                    state_d = SEND_X;
                    ld      = 1'b1;
                    ld_val  = GAP_L;
                end
            end
            SEND_X:  begin timed = 1'b1; nxt = HS_X;    nxt_len = HOLD_L; end
            HS_X:    begin timed = 1'b1; nxt = GAP_X;   nxt_len = GAP_L;  end
            GAP_X:   begin timed = 1'b1; nxt = SEND_Y;  nxt_len = GAP_L;  end
            SEND_Y:  begin timed = 1'b1; nxt = HS_Y;    nxt_len = HOLD_L; end
            HS_Y:    begin timed = 1'b1; nxt = GAP_Y;   nxt_len = GAP_L;  end
            GAP_Y:   begin timed = 1'b1; nxt = WAIT_X2; nxt_len = TMO_L;  end
            SHOW_X2: begin timed = 1'b1; nxt = WAIT_Y2; nxt_len = TMO_L;  end
            RELEASE: begin timed = 1'b1; nxt = IDLE;    nxt_len = '0;     end
            WAIT_X2, WAIT_Y2: begin
                // io output register lags the strobe by one cycle
                if (cap_q) begin
                    cap_d = 1'b0;
                    ld    = 1'b1;
                    if (state_q == WAIT_X2) begin
                        x2_d    = out;
                        state_d = SHOW_X2;
                        ld_val  = GAP_L;
                    end else begin
                        y2_d    = out;
                        state_d = RELEASE;
                        ld_val  = HOLD_L;
                    end
                end else if (write_out) begin
                    cap_d = 1'b1;
                end else if (zero) begin
                    to_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    dec = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (timed) begin
            if (zero) begin
                state_d = nxt;
                ld      = 1'b1;
                ld_val  = nxt_len;
                if (nxt == SEND_Y) in_d = y1_q;
                if (state_q == RELEASE) done_d = 1'b1;
            end else begin
                dec = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            in_q    <= '0;
            y1_q    <= '0;
            x2_q    <= '0;
            y2_q    <= '0;
            to_q    <= 1'b0;
            done_q  <= 1'b0;
            cap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            in_q    <= in_d;
            y1_q    <= y1_d;
            x2_q    <= x2_d;
            y2_q    <= y2_d;
            to_q    <= to_d;
            done_q  <= done_d;
            cap_q   <= cap_d;
        end
    end

    assign in        = in_q;
    assign x2        = x2_q;
    assign y2        = y2_q;
    assign done      = done_q;
    assign timeout   = to_q;
    assign busy      = (state_q != IDLE);
    assign handshake = (state_q == HS_X) || (state_q == HS_Y) ||
                       (state_q == WAIT_Y2) || (state_q == RELEASE);

endmodule

// File: tb/tb_io_host.sv
// Scoreboard bench for io_host: stimulus pushes expected results,
// a monitor pops them on done/timeout; a checker watches handshake timing.
`timescale 1ns/1ps
module tb_io_host;
    import io_pkg::*;

    localparam int N = 8;

    typedef struct packed {
        logic [7:0] x2;
        logic [7:0] y2;
        logic       to;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset, start, write_out;
    logic [N-1:0] x1, y1, out;
    logic [N-1:0] in, x2, y2;
    logic         handshake, busy, done, timeout;

    int   compared   = 0;
    int   mismatched = 0;
    exp_t q[$];
    exp_t e_m;
    logic [7:0] exp_in0 = '0;
    logic [7:0] exp_in1 = '0;

    always #5 clk = ~clk;

    io_host #(
        .N       (N),
        .HOLD    (HOLD_DEF),
        .GAP     (GAP_DEF),
        .TIMEOUT (TIMEOUT_DEF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .x1        (x1),
        .y1        (y1),
        .in        (in),
        .handshake (handshake),
        .out       (out),
        .write_out (write_out),
        .x2        (x2),
        .y2        (y2),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout)
    );

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // scoreboard monitor
    logic to_p = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            to_p = 1'b0;
        end else begin
            if (done || (timeout && !to_p)) begin
                if (q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL sb_unexpected: done=%b timeout=%b, required no event",
                             done, timeout);
                end else begin
                    e_m = q.pop_front();
                    check("sb_x2", x2, e_m.x2);
                    check("sb_y2", y2, e_m.y2);
                    check("sb_timeout", {7'b0, timeout}, {7'b0, e_m.to});
                    check("sb_done", {7'b0, done}, {7'b0, !e_m.to});
                    check("sb_hs_low", {7'b0, handshake}, 8'h00);
                    check("sb_idle", {7'b0, busy}, 8'h00);
                end
            end
            to_p = timeout;
        end
    end

    // handshake protocol checker
    logic       hs_p = 1'b0, busy_p = 1'b0, in_moved = 1'b0;
    logic [7:0] in_rise = '0;
    int         lo_len = 0, hi_len = 0, hs_idx = 0;
    always @(negedge clk) begin
        if (reset) begin
            hs_p   = 1'b0;
            busy_p = 1'b0;
            lo_len = 0;
            hi_len = 0;
            hs_idx = 0;
        end else begin
            if (busy && !busy_p) hs_idx = 0;
            if (handshake && !hs_p) begin
                check("gap_min", {7'b0, (lo_len >= GAP_DEF)}, 8'h01);
                in_rise  = in;
                in_moved = 1'b0;
                hi_len   = 1;
                if (hs_idx == 0) check("in_x1", in, exp_in0);
                if (hs_idx == 1) check("in_y1", in, exp_in1);
            end else if (handshake) begin
                hi_len++;
                if (in !== in_rise) in_moved = 1'b1;
            end
            if (!handshake && hs_p) begin
                check("in_stable", {7'b0, in_moved}, 8'h00);
                if (hs_idx < 2)
                    check("hs_hold", 8'(hi_len), 8'(HOLD_DEF));
                else
                    check("hs_hold_min", {7'b0, (hi_len >= HOLD_DEF)}, 8'h01);
                hs_idx++;
                lo_len = 1;
            end else if (!handshake && lo_len < 1000) begin
                lo_len++;
            end
            hs_p   = handshake;
            busy_p = busy;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hs(input logic lvl, input string what);
        int n;
        n = 0;
        @(negedge clk);
        while (handshake !== lvl && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (handshake !== lvl) begin
            compared++;
            mismatched++;
            $display("FAIL %s: handshake stuck at %b, required %b", what, handshake, lvl);
        end
    endtask

    task automatic wait_idle(input string what);
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) begin
            compared++;
            mismatched++;
            $display("FAIL %s: busy stuck at %b, required 0", what, busy);
        end
    endtask

    task automatic issue_start(input logic [7:0] a, input logic [7:0] b);
        exp_in0 = a;
        exp_in1 = b;
        tick();
        start = 1'b1;
        x1 = a;
        y1 = b;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("start_busy", {7'b0, busy}, 8'h01);
        check("start_to_clr", {7'b0, timeout}, 8'h00);
    endtask

    task automatic strobe(input logic [7:0] v);
        tick();
        write_out = 1'b1;
        tick();
        write_out = 1'b0;
        out = v;
    endtask

    task automatic run_txn(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] r1, input logic [7:0] r2,
                           input bit stray, input bit dup);
        q.push_back('{x2: r1, y2: r2, to: 1'b0});
        issue_start(a, b);
        wait_hs(1'b1, "hs_x_rise");
        if (dup) begin
            tick();
            start = 1'b1;
            x1 = 8'hAA;
            y1 = 8'hBB;
            tick();
            start = 1'b0;
        end
        wait_hs(1'b0, "hs_x_fall");
        wait_hs(1'b1, "hs_y_rise");
        if (stray) strobe(8'h55);
        wait_hs(1'b0, "hs_y_fall");
        repeat (2) tick();
        strobe(r1);
        wait_hs(1'b1, "show_rise");
        strobe(r2);
        wait_idle("txn_end");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: sim time %0t, required finish earlier", $time);
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        x1        = '0;
        y1        = '0;
        out       = '0;
        write_out = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_in", in, 8'h00);
        check("rst_hs", {7'b0, handshake}, 8'h00);
        check("rst_x2", x2, 8'h00);
        check("rst_y2", y2, 8'h00);
        check("rst_busy", {7'b0, busy}, 8'h00);
        check("rst_done", {7'b0, done}, 8'h00);
        check("rst_to", {7'b0, timeout}, 8'h00);

        // normal run
        run_txn(8'h2B, 8'h04, 8'hCC, 8'hEE, 1'b0, 1'b0);

        // no first result: timeout, results retained
        q.push_back('{x2: 8'hCC, y2: 8'hEE, to: 1'b1});
        issue_start(8'h31, 8'h32);
        wait_idle("timeout_end");
        check("to_hs", {7'b0, handshake}, 8'h00);
        check("to_flag", {7'b0, timeout}, 8'h01);

        // stray strobe in HS_Y; start clears timeout
        run_txn(8'h10, 8'h20, 8'h11, 8'h22, 1'b1, 1'b0);

        // start while busy ignored
        run_txn(8'h7F, 8'h80, 8'h33, 8'h44, 1'b0, 1'b1);

        // reset during WAIT_Y2
        issue_start(8'h01, 8'h02);
        wait_hs(1'b1, "r_hs_x_rise");
        wait_hs(1'b0, "r_hs_x_fall");
        wait_hs(1'b1, "r_hs_y_rise");
        wait_hs(1'b0, "r_hs_y_fall");
        repeat (2) tick();
        strobe(8'h99);
        wait_hs(1'b1, "r_show_rise");
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("mid_in", in, 8'h00);
        check("mid_hs", {7'b0, handshake}, 8'h00);
        check("mid_x2", x2, 8'h00);
        check("mid_y2", y2, 8'h00);
        check("mid_busy", {7'b0, busy}, 8'h00);
        check("mid_done", {7'b0, done}, 8'h00);
        check("mid_to", {7'b0, timeout}, 8'h00);

        // fresh run after reset
        run_txn(8'h5A, 8'hA5, 8'h0F, 8'hF0, 1'b0, 1'b0);

        // reset beats start on the same edge
        tick();
        reset = 1'b1;
        start = 1'b1;
        x1 = 8'h3C;
        tick();
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("prio_busy", {7'b0, busy}, 8'h00);
        check("prio_in", in, 8'h00);

        repeat (20) tick();
        check("sb_drain", 8'(q.size()), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
